// File: rtl/pixel_stream_fifo_if.sv
// pixel_stream_fifo_if: AXI-Stream style upstream (s_*) and downstream (m_*)
// handshake bundle for the pixel stream FIFO. The FIFO takes the slave
// modport; the driving/consuming environment takes the master modport.
interface pixel_stream_fifo_if;
   logic [31:0] s_TDATA;
   logic        s_TVALID;
   logic        s_TREADY;
   logic [31:0] m_TDATA;
   logic        m_TVALID;
   logic        m_TREADY;

   modport slave (
      input  s_TDATA, s_TVALID, m_TREADY,
      output s_TREADY, m_TDATA, m_TVALID
   );

   modport master (
      output s_TDATA, s_TVALID, m_TREADY,
      input  s_TREADY, m_TDATA, m_TVALID
   );
endinterface

// File: rtl/pixel_stream_fifo.sv
// pixel_stream_fifo: elastic first-word-fall-through buffer for 32-bit pixel
// words (R[7:0], G[15:8], B[23:16], metadata[31:24]) carried unmodified.
// Occupancy is tracked in a dedicated counter, so full/empty never depend on
// pointer comparison. Define PSF_STATS_EN to add popped-word and
// start-of-frame counters (frame_cnt, pixel_cnt).
module pixel_stream_fifo #(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned AFULL_THRESH = 12,
   parameter logic [7:0]  SOF_CODE     = 8'h01
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   pixel_stream_fifo_if.slave     bus,
   output logic [$clog2(DEPTH):0] level,
   output logic                   almost_full
`ifdef PSF_STATS_EN
   ,
   output logic [15:0]            frame_cnt,
   output logic [31:0]            pixel_cnt
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_L = CW'(AFULL_THRESH);

   if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (AFULL_THRESH > DEPTH)) begin : g_param_check
      $error("pixel_stream_fifo: DEPTH must be a power of 2 >= 4 and AFULL_THRESH <= DEPTH");
   end

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          afull_q;
   logic          s_tready_s;
   logic          m_tvalid_s;
   logic          push_s;
   logic          pop_s;

   // Ready drops while full (no same-cycle passthrough) and during flush.
   assign s_tready_s   = (cnt_q != DEPTH_L) & ~flush;
   assign m_tvalid_s   = (cnt_q != {CW{1'b0}});
   assign push_s       = bus.s_TVALID & s_tready_s;
   assign pop_s        = m_tvalid_s & bus.m_TREADY;

   assign bus.s_TREADY = s_tready_s;
   assign bus.m_TVALID = m_tvalid_s;
   assign bus.m_TDATA  = mem_q[rp_q];
   assign level        = cnt_q;
   assign almost_full  = afull_q;

   // Next-state pointers and occupancy; flush overrides any push or pop.
   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (flush) begin
         wp_d  = {AW{1'b0}};
         rp_d  = {AW{1'b0}};
         cnt_d = {CW{1'b0}};
      end else begin
         if (push_s) begin
            wp_d = wp_q + AW'(1);
         end else begin
            wp_d = wp_q;
         end
         if (pop_s) begin
            rp_d = rp_q + AW'(1);
         end else begin
            rp_d = rp_q;
         end
         case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Control state; almost_full follows next-state count to line up with level.
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q    <= {AW{1'b0}};
         rp_q    <= {AW{1'b0}};
         cnt_q   <= {CW{1'b0}};
         afull_q <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         afull_q <= (cnt_d >= AFULL_L);
      end
   end

   // Storage write; contents are never cleared, only pointers are.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wp_q] <= bus.s_TDATA;
      end
   end

`ifdef PSF_STATS_EN
   logic [15:0] frame_cnt_q;
   logic [31:0] pixel_cnt_q;

   assign frame_cnt = frame_cnt_q;
   assign pixel_cnt = pixel_cnt_q;

   // Popped-word and start-of-frame counters; cleared by rst only, not flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= 16'd0;
         pixel_cnt_q <= 32'd0;
      end else if (pop_s) begin
         pixel_cnt_q <= pixel_cnt_q + 32'd1;
         if (bus.m_TDATA[31:24] == SOF_CODE) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
      end
   end
`else
   // Statistics disabled: SOF_CODE has no consumer and no counter flops exist.
   logic [7:0] unused_sof_s;
   assign unused_sof_s = SOF_CODE;
`endif

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// tb_pixel_stream_fifo: directed self-checking bench. A vector table covers
// single-word latency, stall stability, push/pop on an empty FIFO and flush;
// hand-written sequences cover fill/almost-full, wrap under simultaneous
// push/pop, flush at level 9, reset mid-burst and (with PSF_STATS_EN) stats.
module tb_pixel_stream_fifo;

   logic       clk;
   logic       rst;
   logic       flush;
   logic [4:0] level;
   logic       almost_full;
`ifdef PSF_STATS_EN
   logic [15:0] frame_cnt;
   logic [31:0] pixel_cnt;
`endif

   int total;
   int bad;

   pixel_stream_fifo_if bus ();

   pixel_stream_fifo #(
      .DEPTH        (16),
      .AFULL_THRESH (12),
      .SOF_CODE     (8'h01)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .bus         (bus.slave),
      .level       (level),
      .almost_full (almost_full)
`ifdef PSF_STATS_EN
      ,
      .frame_cnt   (frame_cnt),
      .pixel_cnt   (pixel_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        f;
      logic        v;
      logic [31:0] d;
      logic        r;
      logic        e_sr;
      logic        e_mv;
      logic        chk_d;
      logic [31:0] e_d;
      logic [4:0]  e_lvl;
      logic        e_af;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Apply inputs just after a rising edge, then wait to the falling edge to sample.
   task automatic drive(input logic f, input logic v, input logic [31:0] d, input logic r);
      @(posedge clk);
      #1;
      flush        = f;
      bus.s_TVALID = v;
      bus.s_TDATA  = d;
      bus.m_TREADY = r;
      @(negedge clk);
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      rst          = 1'b1;
      flush        = 1'b0;
      bus.s_TVALID = 1'b0;
      bus.s_TDATA  = 32'h0;
      bus.m_TREADY = 1'b0;

      //            f     v     d              r     sr    mv    chk   e_d            lvl   af
      vecs[0]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 5'd0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 32'hAA112233, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 5'd0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'hAA112233, 5'd1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'hAA112233, 5'd1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'hAA112233, 5'd1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'hAA112233, 5'd1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1, 32'hAA112233, 5'd1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 5'd0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 32'h01020304, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 5'd0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 32'h05060708, 1'b1, 1'b1, 1'b1, 1'b1, 32'h01020304, 5'd1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h05060708, 5'd1, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h05060708, 5'd1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 5'd0, 1'b0};

      // Reset held for two cycles, then idle state.
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_s_tready", 32'(bus.s_TREADY), 32'd1);
      chk("rst_m_tvalid", 32'(bus.m_TVALID), 32'd0);
      chk("rst_level",    32'(level),        32'd0);
      chk("rst_afull",    32'(almost_full),  32'd0);

      // Table-driven vectors.
      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].f, vecs[i].v, vecs[i].d, vecs[i].r);
         chk($sformatf("vec%0d_s_tready", i), 32'(bus.s_TREADY), 32'(vecs[i].e_sr));
         chk($sformatf("vec%0d_m_tvalid", i), 32'(bus.m_TVALID), 32'(vecs[i].e_mv));
         chk($sformatf("vec%0d_level", i),    32'(level),        32'(vecs[i].e_lvl));
         chk($sformatf("vec%0d_afull", i),    32'(almost_full),  32'(vecs[i].e_af));
         if (vecs[i].chk_d) begin
            chk($sformatf("vec%0d_m_tdata", i), bus.m_TDATA, vecs[i].e_d);
         end
      end

      // Fill to DEPTH with the sink stalled.
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, 32'(i), 1'b0);
         chk($sformatf("fill%0d_level", i),    32'(level),        32'(i));
         chk($sformatf("fill%0d_afull", i),    32'(almost_full),  (i >= 12) ? 32'd1 : 32'd0);
         chk($sformatf("fill%0d_s_tready", i), 32'(bus.s_TREADY), 32'd1);
      end
      // A 17th word held valid while full is never accepted.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 32'h00000099, 1'b0);
         chk("full_s_tready", 32'(bus.s_TREADY), 32'd0);
         chk("full_level",    32'(level),        32'd16);
         chk("full_afull",    32'(almost_full),  32'd1);
         chk("full_head",     bus.m_TDATA,       32'd0);
      end
      // Drain in order.
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1);
         chk($sformatf("drain%0d_data", i),  bus.m_TDATA,       32'(i));
         chk($sformatf("drain%0d_level", i), 32'(level),        32'(16 - i));
         chk($sformatf("drain%0d_afull", i), 32'(almost_full),  ((16 - i) >= 12) ? 32'd1 : 32'd0);
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk("drained_level",    32'(level),        32'd0);
      chk("drained_m_tvalid", 32'(bus.m_TVALID), 32'd0);

      // Simultaneous push/pop at level 5 across pointer wrap.
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 32'(100 + i), 1'b0);
      end
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 1'b1, 32'(105 + k), 1'b1);
         chk($sformatf("pp%0d_data", k),  bus.m_TDATA, 32'(100 + k));
         chk($sformatf("pp%0d_level", k), 32'(level),  32'd5);
      end
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1);
         chk($sformatf("pptail%0d_data", k),  bus.m_TDATA, 32'(120 + k));
         chk($sformatf("pptail%0d_level", k), 32'(level),  32'(5 - k));
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk("pp_empty_level", 32'(level), 32'd0);

      // Flush at level 9 with upstream valid.
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, 1'b1, 32'(200 + i), 1'b0);
      end
      drive(1'b1, 1'b1, 32'hDEAD0000, 1'b0);
      chk("flush_s_tready", 32'(bus.s_TREADY), 32'd0);
      chk("flush_level",    32'(level),        32'd9);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk("postflush_level",    32'(level),        32'd0);
      chk("postflush_m_tvalid", 32'(bus.m_TVALID), 32'd0);
      chk("postflush_afull",    32'(almost_full),  32'd0);
      chk("postflush_s_tready", 32'(bus.s_TREADY), 32'd1);
      drive(1'b0, 1'b1, 32'hC0FFEE00, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("postflush_first_data", bus.m_TDATA,   32'hC0FFEE00);
      chk("postflush_first_lvl",  32'(level),    32'd1);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk("postflush_empty", 32'(level), 32'd0);

      // Reset mid-burst discards stored words.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 32'(300 + i), 1'b0);
      end
      @(posedge clk);
      #1;
      rst          = 1'b1;
      bus.s_TDATA  = 32'h00000444;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.s_TVALID = 1'b0;
      @(negedge clk);
      chk("midrst_level",    32'(level),        32'd0);
      chk("midrst_m_tvalid", 32'(bus.m_TVALID), 32'd0);
      chk("midrst_s_tready", 32'(bus.s_TREADY), 32'd1);
      chk("midrst_afull",    32'(almost_full),  32'd0);
      drive(1'b0, 1'b1, 32'h00000555, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("midrst_next_data", bus.m_TDATA, 32'h00000555);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk("midrst_drained", 32'(level), 32'd0);

`ifdef PSF_STATS_EN
      // Statistics: 3 frames of 4 words, SOF metadata on each first word.
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("stats_rst_pixel", pixel_cnt,        32'd0);
      chk("stats_rst_frame", 32'(frame_cnt),   32'd0);
      for (int f = 0; f < 3; f++) begin
         for (int w = 0; w < 4; w++) begin
            drive(1'b0, 1'b1, {((w == 0) ? 8'h01 : 8'h00), 24'(f * 4 + w)}, 1'b0);
         end
      end
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1);
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk("stats_pixel", pixel_cnt,      32'd12);
      chk("stats_frame", 32'(frame_cnt), 32'd3);
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk("stats_flush_pixel", pixel_cnt,      32'd12);
      chk("stats_flush_frame", 32'(frame_cnt), 32'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pixel_stream_fifo.md
Name: pixel_stream_fifo

Overview:
- Elastic AXI-Stream buffer that sits directly downstream of the video enhancement core's master stream output (down_TDATA/down_TVALID/down_TREADY).
- Absorbs downstream back-pressure bursts so the datapath is not stalled every time the sink deasserts TREADY.
- 32-bit pixel words (R[7:0], G[15:8], B[23:16], metadata[31:24]) pass through unmodified and in order.
- Exposes fill level and almost-full status for system monitoring.

Parameters:
DEPTH, 16, number of 32-bit entries; power of 2, minimum 4
AFULL_THRESH, 12, level at or above which almost_full asserts; must be less than or equal to DEPTH
SOF_CODE, 8'h01, metadata byte value marking start-of-frame; used only by the optional stats feature

Ports:
clk  in  1  single clock; same clock that drives the datapath
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous clear of FIFO contents, active-high
s_TDATA  in  32  upstream pixel word, FDATA layout
s_TVALID  in  1  upstream word valid
s_TREADY  out  1  FIFO can accept a word
m_TDATA  out  32  downstream pixel word
m_TVALID  out  1  downstream word valid
m_TREADY  in  1  downstream sink ready
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
almost_full  out  1  level >= AFULL_THRESH
frame_cnt  out  16  frames popped; present only with PSF_STATS_EN
pixel_cnt  out  32  words popped; present only with PSF_STATS_EN

Behaviour:
- Storage: register array of DEPTH x 32, with write pointer wp and read pointer rp, each $clog2(DEPTH) bits and wrapping naturally. Occupancy count cnt is a separate register.
- push = s_TVALID & s_TREADY; pop = m_TVALID & m_TREADY.
- s_TREADY = (cnt != DEPTH) & ~flush. It is combinational from registers plus flush. No passthrough when full: a pop in the same cycle does not raise s_TREADY.
- m_TVALID = (cnt != 0). m_TDATA = mem[rp], first-word-fall-through.
- Latency: a word pushed into an empty FIFO at edge N is presented on m_TDATA with m_TVALID=1 in the cycle after edge N. Minimum latency is 1 cycle.
- cnt update per cycle:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged; write goes to wp and read advances rp in the same cycle.
- Full (cnt=DEPTH): s_TREADY=0, no writes. Empty (cnt=0): m_TVALID=0, no pops, and m_TDATA is don't-care.
- Pointer wrap: wp and rp wrap from DEPTH-1 to 0. Full and empty are distinguished by cnt only, never by pointer compare.
- m_TDATA must hold stable while m_TVALID=1 and m_TREADY=0, per the AXI-Stream rule.
- level = cnt. almost_full is registered and derived from the next-state cnt, so it is aligned with level in the same cycle.
- flush=1 sets wp=rp=cnt=0 and almost_full=0 at the next edge. Flush has priority over push and pop. During the flush cycle s_TREADY=0, and any pop handshake that occurs is still a valid transfer of the current head word. Memory contents are not cleared.
- rst=1: wp=rp=cnt=0, almost_full=0, stats counters=0. Outputs after reset: s_TREADY=1, m_TVALID=0, level=0, almost_full=0. Reset mid-burst discards all stored words with no partial output.
- No pixel data is modified. The metadata byte is carried transparently.

Optional Feature:
- Macro: PSF_STATS_EN.
- Defined: frame_cnt and pixel_cnt ports exist.
  - pixel_cnt increments on every pop and wraps at 2^32.
  - frame_cnt increments on every pop whose m_TDATA[31:24]==SOF_CODE and wraps at 2^16.
  - Both counters clear on rst only; flush does not clear them.
- Undefined: the ports and counters are absent and there are no extra flops.

Test Plan:
- Reset then idle, rst=1 for 2 cycles -> s_TREADY=1, m_TVALID=0, level=0, almost_full=0.
- Single word: push 32'hAA112233 with m_TREADY=0 -> next cycle m_TVALID=1, m_TDATA=32'hAA112233, level=1; data holds stable over 5 stall cycles; raise m_TREADY -> popped, level=0.
- Fill with DEPTH=16, m_TREADY=0, push 0..15 -> almost_full rises when level reaches 12; s_TREADY=0 at level 16; a 17th word with s_TVALID held is not accepted; drain -> words come out 0..15 in order.
- Simultaneous push/pop at level=5, 20 cycles with both handshakes every cycle -> level stays 5, order preserved across pointer wrap.
- Flush at level=9 with s_TVALID=1 -> s_TREADY=0 in the flush cycle, then level=0, m_TVALID=0, and the next pushed word is the first one output.
- PSF_STATS_EN, 3 frames of 4 words each, metadata 8'h01 on the first word of each frame -> after drain, pixel_cnt=12 and frame_cnt=3; a flush leaves both unchanged.
